// File: rtl/ifetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// end-of-program word and the opcode field layout used by decode and benches.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 29;

  localparam logic [2:0] OPC_LW  = 3'b000;
  localparam logic [2:0] OPC_SW  = 3'b001;
  localparam logic [2:0] OPC_BEQ = 3'b010;
  localparam logic [2:0] OPC_BLT = 3'b011;
  localparam logic [2:0] OPC_ADD = 3'b100;
  localparam logic [2:0] OPC_SUB = 3'b101;
  localparam logic [2:0] OPC_AND = 3'b110;
  localparam logic [2:0] OPC_OR  = 3'b111;

  function automatic logic [2:0] opcode_of(input logic [31:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/ifetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and decode.
// master = the sequencer, slave = its environment (memory, decode, control).
interface ifetch_sequencer_if #(
  parameter int ADDR_W = 16
);

  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;
  logic              halted;
  logic              fault;

  modport master (
    input  start, start_pc, imem_data, inst_ready, redirect_valid, redirect_pc,
    output imem_addr, inst_valid, inst_out, inst_pc, busy, halted, fault
  );

  modport slave (
    output start, start_pc, imem_data, inst_ready, redirect_valid, redirect_pc,
    input  imem_addr, inst_valid, inst_out, inst_pc, busy, halted, fault
  );

endinterface

// File: rtl/ifetch_sequencer_slot.sv
// One-entry output register holding a fetched word and its PC, offered to
// decode with valid/ready; flush drops the entry regardless of ready.
module ifetch_slot
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              flush,
  input  logic              ready,
  input  logic [31:0]       data_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [31:0]       data,
  output logic [ADDR_W-1:0] pc,
  output logic              free
);

  // The slot may take a new word when empty or when its current word leaves now.
  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= data_in;
      pc    <= pc_in;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_sequencer.sv
// Fetch controller: owns the PC, reads the instruction memory and feeds the
// output slot. Optional macro IFETCH_BOUND_CHK_EN turns address wrap into a fault.
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] HALT_WORD = ifetch_pkg::HALT_WORD
) (
  input logic              clk,
  input logic              rst_n,
  ifetch_sequencer_if.master bus
);

  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("ifetch_sequencer: DEPTH must be a power of 2");
  end

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    return a & ADDR_MASK;
  endfunction

`ifdef IFETCH_BOUND_CHK_EN
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a & ~ADDR_MASK) != '0;
  endfunction
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              slot_capture;
  logic              slot_flush;
  logic              slot_free;
`ifdef IFETCH_BOUND_CHK_EN
  logic              fault_q, fault_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

`ifdef IFETCH_BOUND_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  // Redirect outranks everything in FETCH; otherwise the memory word is either
  // issued into the slot or, if it is the halt word, ends the program.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    halted_d     = halted_q;
    slot_capture = 1'b0;
    slot_flush   = 1'b0;
`ifdef IFETCH_BOUND_CHK_EN
    fault_d      = fault_q;
`endif
    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
`ifdef IFETCH_BOUND_CHK_EN
          if (out_of_range(bus.start_pc)) begin
            state_d  = HALTED;
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end else begin
            state_d  = FETCH;
            pc_d     = bus.start_pc;
            halted_d = 1'b0;
            fault_d  = 1'b0;
          end
`else
          state_d  = FETCH;
          pc_d     = wrap_addr(bus.start_pc);
          halted_d = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (bus.redirect_valid) begin
          slot_flush = 1'b1;
`ifdef IFETCH_BOUND_CHK_EN
          if (out_of_range(bus.redirect_pc)) begin
            state_d  = HALTED;
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end else begin
            pc_d = bus.redirect_pc;
          end
`else
          pc_d = wrap_addr(bus.redirect_pc);
`endif
        end else if (slot_free) begin
`ifdef IFETCH_BOUND_CHK_EN
          // pc only leaves the array by stepping past DEPTH-1; that faults here.
          if (out_of_range(pc_q)) begin
            slot_flush = 1'b1;
            state_d    = HALTED;
            halted_d   = 1'b1;
            fault_d    = 1'b1;
          end else
`endif
          if (bus.imem_data == HALT_WORD) begin
            slot_flush = 1'b1;
            state_d    = HALTED;
            halted_d   = 1'b1;
          end else begin
            slot_capture = 1'b1;
`ifdef IFETCH_BOUND_CHK_EN
            pc_d = pc_q + ADDR_W'(1);
`else
            pc_d = wrap_addr(pc_q + ADDR_W'(1));
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  ifetch_slot #(
    .ADDR_W (ADDR_W)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (slot_capture),
    .flush   (slot_flush),
    .ready   (bus.inst_ready),
    .data_in (bus.imem_data),
    .pc_in   (pc_q),
    .valid   (bus.inst_valid),
    .data    (bus.inst_out),
    .pc      (bus.inst_pc),
    .free    (slot_free)
  );

  assign bus.imem_addr = pc_q;
  assign bus.busy      = (state_q == FETCH);
  assign bus.halted    = halted_q;
`ifdef IFETCH_BOUND_CHK_EN
  assign bus.fault     = fault_q;
`else
  assign bus.fault     = 1'b0;
`endif

endmodule

// File: doc/ifetch_sequencer.md
Name: ifetch_sequencer

Overview:
- Fetch controller for the 256x32 combinational-read instruction memory. Owns the program counter and drives the memory address.
- Registers each fetched word into a one-entry output slot and offers it to decode with a valid/ready handshake.
- Accepts branch redirects and stops the program on the all-zero end-of-program word.

Parameters:
- ADDR_W, 16, width of the PC and memory address.
- DEPTH, 256, number of instruction words; must be a power of 2.
- HALT_WORD, 32'h0000_0000, end-of-program encoding.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin fetching at start_pc.
- start_pc  in  ADDR_W  initial PC, sampled with start.
- imem_addr  out  ADDR_W  address to instruction memory; equals pc.
- imem_data  in  32  read data from instruction memory, valid in the same cycle.
- inst_valid  out  1  output slot holds an instruction.
- inst_ready  in  1  decode accepts the slot this cycle.
- inst_out  out  32  fetched instruction.
- inst_pc  out  ADDR_W  address of inst_out.
- redirect_valid  in  1  branch taken; flush and refetch.
- redirect_pc  in  ADDR_W  branch target.
- busy  out  1  state is FETCH.
- halted  out  1  end-of-program reached.
- fault  out  1  address-range fault (optional feature only).

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset, which may assert at any time including mid-fetch, immediately forces:
  - state=IDLE, pc=0, so imem_addr=0;
  - inst_valid=0, inst_out=0, inst_pc=0;
  - halted=0, fault=0, busy=0.
- States: IDLE, FETCH, HALTED.
- IDLE:
  - start=1 → pc<=start_pc mod DEPTH, go to FETCH.
  - redirect_valid is ignored.
- FETCH, slot free (inst_valid=0, or inst_ready=1 this cycle):
  - Non-halt word: capture. inst_out<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+1.
  - Latency: an instruction appears one clock after its address is driven.
  - Sustained throughput is 1 instruction/cycle while inst_ready=1.
- FETCH, slot held (inst_valid=1 and inst_ready=0): inst_out, inst_pc and pc are frozen.
- Halt word: when imem_data==HALT_WORD and the slot is free, the word is not issued.
  - inst_valid<=0, state<=HALTED, halted<=1, pc is held.
- Redirect (FETCH only) has priority over capture and halt.
  - inst_valid<=0 and pc<=redirect_pc mod DEPTH.
  - The first fetch from the target is registered on the following edge.
  - If inst_ready=1 in the same cycle, the old slot counts as consumed; it is not re-offered.
- HALTED:
  - inst_valid=0; halted stays 1.
  - redirect_valid is ignored.
  - start=1 → halted<=0, pc<=start_pc, go to FETCH.
- Wrap-around: pc increments modulo DEPTH (255 → 0) when the optional feature is absent.
- Simultaneous start and redirect: in IDLE/HALTED start wins; in FETCH start is ignored.
- busy=1 exactly while state==FETCH.

Optional Feature:
- Macro: IFETCH_BOUND_CHK_EN.
- Defined:
  - An increment from DEPTH-1, or a redirect_pc/start_pc ≥ DEPTH, does not wrap.
  - Instead: fault<=1, halted<=1, state<=HALTED, inst_valid<=0.
  - fault clears only on reset or start.
- Undefined: fault is tied 0 and addresses wrap modulo DEPTH.

Decomposition:
- Package ifetch_pkg holds:
  - state encoding (IDLE=2'd0, FETCH=2'd1, HALTED=2'd2);
  - HALT_WORD;
  - opcode field position [31:29] and opcode constants (LW=000, SW=001, BEQ=010, BLT=011, ADD=100, SUB=101, AND=110, OR=111) for benches and decode.
- One natural sub-module, ifetch_slot: the one-entry output register with valid/ready and flush input. The FSM and PC stay in the top.

Test Plan:
- Basic stream: memory 0..3 = A,B,C,D with word 4 = 0; start_pc=0; inst_ready=1.
  - A,B,C,D issued on consecutive cycles with inst_pc 0..3.
  - halted=1 on the 5th cycle; inst_valid never asserted for word 4.
- Backpressure: inst_ready=0 for 3 cycles after the first capture.
  - inst_out=A and inst_pc=0 stable, imem_addr stuck at 1.
  - B follows one cycle after ready returns.
- Redirect: redirect_valid with redirect_pc=5 while slot holds pc 3.
  - Next cycle inst_valid=0; the following cycle inst_pc=5.
  - pc 4 is never issued.
- Wrap/bound: start_pc=255, nonzero words at 255 and 0.
  - Without macro: inst_pc 255 then 0.
  - With IFETCH_BOUND_CHK_EN: 255 is issued, then fault=1, halted=1.
- Reset mid-operation: drop rst_n between edges while inst_valid=1 at pc 7.
  - Outputs go to reset values immediately, before the next edge; state=IDLE.
- Restart from HALTED: start with start_pc=2.
  - halted drops, inst_pc=2 appears one cycle after entering FETCH.
  - redirect pulses while HALTED have no effect.
